// File: rtl/axi4_lite_cmd_master_if.sv
// axi4_lite_if: AXI4-Lite bus bundle with master and slave views.
// Widths are parameters and must match the master using it.
interface axi4_lite_if #(
  parameter int ADDR_BIT_WIDTH = 32,
  parameter int DATA_BIT_WIDTH = 32
) ();
  logic [ADDR_BIT_WIDTH-1:0]   awaddr;
  logic [2:0]                  awprot;
  logic                        awvalid;
  logic                        awready;
  logic [DATA_BIT_WIDTH-1:0]   wdata;
  logic [DATA_BIT_WIDTH/8-1:0] wstrb;
  logic                        wvalid;
  logic                        wready;
  logic [1:0]                  bresp;
  logic                        bvalid;
  logic                        bready;
  logic [ADDR_BIT_WIDTH-1:0]   araddr;
  logic [2:0]                  arprot;
  logic                        arvalid;
  logic                        arready;
  logic [DATA_BIT_WIDTH-1:0]   rdata;
  logic [1:0]                  rresp;
  logic                        rvalid;
  logic                        rready;

  modport master (
    output awaddr, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arprot, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arprot, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi4_lite_cmd_master.sv
// axi4_lite_cmd_master: valid/ready command stream to single AXI4-Lite beats.
// Optional AXI4_LITE_CMD_MASTER_ALIGN_CHECK_EN: misaligned cmds get SLVERR.
module axi4_lite_cmd_master #(
  parameter int ADDR_BIT_WIDTH    = 32,
  parameter int DATA_BIT_WIDTH    = 32,
  parameter int ERR_CNT_BIT_WIDTH = 16
) (
  input  logic                         i_clk,
  input  logic                         i_async_rst_n,
  input  logic                         i_cmd_valid,
  output logic                         o_cmd_ready,
  input  logic                         i_cmd_we,
  input  logic [ADDR_BIT_WIDTH-1:0]    i_cmd_addr,
  input  logic [DATA_BIT_WIDTH-1:0]    i_cmd_wdata,
  input  logic [DATA_BIT_WIDTH/8-1:0]  i_cmd_wstrb,
  output logic                         o_rsp_valid,
  input  logic                         i_rsp_ready,
  output logic                         o_rsp_we,
  output logic [DATA_BIT_WIDTH-1:0]    o_rsp_rdata,
  output logic [1:0]                   o_rsp_resp,
  output logic                         o_busy,
  output logic [ERR_CNT_BIT_WIDTH-1:0] o_err_cnt,
  axi4_lite_if.master                  if_m_axi4_lite
);

  localparam int STRB_W = DATA_BIT_WIDTH / 8;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR      = 3'd1;
  localparam logic [2:0] S_WR_RESP = 3'd2;
  localparam logic [2:0] S_RD_ADDR = 3'd3;
  localparam logic [2:0] S_RD_DATA = 3'd4;
  localparam logic [2:0] S_RSP     = 3'd5;

  logic [2:0] state_q, state_d;
  logic       aw_done_q, aw_done_d;
  logic       w_done_q, w_done_d;
  logic       awvalid_q, awvalid_d;
  logic       wvalid_q, wvalid_d;
  logic       arvalid_q, arvalid_d;
  logic       bready_q, bready_d;
  logic       rready_q, rready_d;

  logic [ADDR_BIT_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_BIT_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]         wstrb_q, wstrb_d;

  logic                         rsp_valid_q, rsp_valid_d;
  logic                         rsp_we_q, rsp_we_d;
  logic [DATA_BIT_WIDTH-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic [1:0]                   rsp_resp_q, rsp_resp_d;
  logic [ERR_CNT_BIT_WIDTH-1:0] err_cnt_q, err_cnt_d;

  logic aw_hs;
  logic w_hs;
  logic err_hit;
  logic misalign;

`ifdef AXI4_LITE_CMD_MASTER_ALIGN_CHECK_EN
  localparam int LSB_W = $clog2(STRB_W);
  assign misalign = |i_cmd_addr[LSB_W-1:0];
`else
  assign misalign = 1'b0;
`endif

  assign aw_hs = awvalid_q & if_m_axi4_lite.awready;
  assign w_hs  = wvalid_q & if_m_axi4_lite.wready;

  // Next-state and datapath decode for the single-outstanding FSM.
  always_comb begin
    state_d     = state_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    bready_d    = bready_q;
    rready_d    = rready_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_valid_d = rsp_valid_q;
    rsp_we_d    = rsp_we_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    err_cnt_d   = err_cnt_q;
    err_hit     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (i_cmd_valid) begin
          addr_d  = i_cmd_addr;
          wdata_d = i_cmd_wdata;
          wstrb_d = i_cmd_wstrb;
          if (misalign) begin
            state_d     = S_RSP;
            rsp_valid_d = 1'b1;
            rsp_we_d    = i_cmd_we;
            rsp_rdata_d = '0;
            rsp_resp_d  = 2'b10;
            err_hit     = 1'b1;
          end else if (i_cmd_we) begin
            state_d   = S_WR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end else begin
            state_d   = S_RD_ADDR;
            arvalid_d = 1'b1;
          end
        end
      end
      S_WR: begin
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if (aw_done_d && w_done_d) begin
          state_d   = S_WR_RESP;
          bready_d  = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      S_WR_RESP: begin
        if (if_m_axi4_lite.bvalid && bready_q) begin
          state_d     = S_RSP;
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_we_d    = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = if_m_axi4_lite.bresp;
          err_hit     = |if_m_axi4_lite.bresp;
        end
      end
      S_RD_ADDR: begin
        if (arvalid_q && if_m_axi4_lite.arready) begin
          state_d   = S_RD_DATA;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      S_RD_DATA: begin
        if (if_m_axi4_lite.rvalid && rready_q) begin
          state_d     = S_RSP;
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_we_d    = 1'b0;
          rsp_rdata_d = if_m_axi4_lite.rdata;
          rsp_resp_d  = if_m_axi4_lite.rresp;
          err_hit     = |if_m_axi4_lite.rresp;
        end
      end
      S_RSP: begin
        if (i_rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (err_hit && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_BIT_WIDTH'(1);
    end
  end

  // State and registered outputs; reset aborts any transaction.
  always_ff @(posedge i_clk or negedge i_async_rst_n) begin
    if (!i_async_rst_n) begin
      state_q     <= S_IDLE;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= 2'b00;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      bready_q    <= bready_d;
      rready_q    <= rready_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_we_q    <= rsp_we_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign o_cmd_ready = (state_q == S_IDLE);
  assign o_busy      = (state_q != S_IDLE);
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_we    = rsp_we_q;
  assign o_rsp_rdata = rsp_rdata_q;
  assign o_rsp_resp  = rsp_resp_q;
  assign o_err_cnt   = err_cnt_q;

  assign if_m_axi4_lite.awaddr  = addr_q;
  assign if_m_axi4_lite.awprot  = 3'b000;
  assign if_m_axi4_lite.awvalid = awvalid_q;
  assign if_m_axi4_lite.wdata   = wdata_q;
  assign if_m_axi4_lite.wstrb   = wstrb_q;
  assign if_m_axi4_lite.wvalid  = wvalid_q;
  assign if_m_axi4_lite.bready  = bready_q;
  assign if_m_axi4_lite.araddr  = addr_q;
  assign if_m_axi4_lite.arprot  = 3'b000;
  assign if_m_axi4_lite.arvalid = arvalid_q;
  assign if_m_axi4_lite.rready  = rready_q;

endmodule

// File: tb/tb_axi4_lite_cmd_master.sv
// tb_axi4_lite_cmd_master: directed bench with memory slave and response model.
// Define AXI4_LITE_CMD_MASTER_ALIGN_CHECK_EN to also cover alignment rejection.
module tb_axi4_lite_cmd_master;

  localparam logic [31:0] ERR_ADDR = 32'h100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_cmd_valid = 1'b0;
  logic        o_cmd_ready;
  logic        i_cmd_we = 1'b0;
  logic [31:0] i_cmd_addr = '0;
  logic [31:0] i_cmd_wdata = '0;
  logic [3:0]  i_cmd_wstrb = '0;
  logic        o_rsp_valid;
  logic        i_rsp_ready = 1'b1;
  logic        o_rsp_we;
  logic [31:0] o_rsp_rdata;
  logic [1:0]  o_rsp_resp;
  logic        o_busy;
  logic [15:0] o_err_cnt;

  always #5 clk = ~clk;

  axi4_lite_if #(.ADDR_BIT_WIDTH(32), .DATA_BIT_WIDTH(32)) bus ();

  axi4_lite_cmd_master #(
    .ADDR_BIT_WIDTH(32),
    .DATA_BIT_WIDTH(32),
    .ERR_CNT_BIT_WIDTH(16)
  ) dut (
    .i_clk         (clk),
    .i_async_rst_n (rst_n),
    .i_cmd_valid   (i_cmd_valid),
    .o_cmd_ready   (o_cmd_ready),
    .i_cmd_we      (i_cmd_we),
    .i_cmd_addr    (i_cmd_addr),
    .i_cmd_wdata   (i_cmd_wdata),
    .i_cmd_wstrb   (i_cmd_wstrb),
    .o_rsp_valid   (o_rsp_valid),
    .i_rsp_ready   (i_rsp_ready),
    .o_rsp_we      (o_rsp_we),
    .o_rsp_rdata   (o_rsp_rdata),
    .o_rsp_resp    (o_rsp_resp),
    .o_busy        (o_busy),
    .o_err_cnt     (o_err_cnt),
    .if_m_axi4_lite(bus)
  );

  int checks = 0;
  int passes = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endfunction

  // ---------------- memory slave with programmable ready delays
  int aw_delay = 0;
  int ar_delay = 0;
  int aw_cnt, ar_cnt;
  logic [31:0] smem [logic [31:0]];
  logic        aw_got, w_got, s_bvalid, s_rvalid;
  logic [31:0] s_awaddr, s_wdata, s_rdata;
  logic [1:0]  s_bresp, s_rresp;
  logic        sl_aw, sl_w;
  logic [31:0] sl_a, sl_d;

  assign bus.awready = (aw_cnt >= aw_delay);
  assign bus.wready  = 1'b1;
  assign bus.arready = (ar_cnt >= ar_delay);
  assign bus.bvalid  = s_bvalid;
  assign bus.bresp   = s_bresp;
  assign bus.rvalid  = s_rvalid;
  assign bus.rdata   = s_rdata;
  assign bus.rresp   = s_rresp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_cnt <= 0; ar_cnt <= 0;
      aw_got <= 0; w_got <= 0;
      s_awaddr <= '0; s_wdata <= '0;
      s_bvalid <= 0; s_bresp <= '0;
      s_rvalid <= 0; s_rresp <= '0; s_rdata <= '0;
    end else begin
      sl_aw = aw_got; sl_a = s_awaddr;
      sl_w = w_got; sl_d = s_wdata;
      if (bus.awvalid && bus.awready) begin
        sl_aw = 1; sl_a = bus.awaddr; aw_cnt <= 0;
      end else if (bus.awvalid) aw_cnt <= aw_cnt + 1;
      if (bus.wvalid && bus.wready) begin
        sl_w = 1; sl_d = bus.wdata;
      end
      if (sl_aw && sl_w && !s_bvalid) begin
        s_bvalid <= 1;
        s_bresp <= (sl_a == ERR_ADDR) ? 2'b10 : 2'b00;
        if (sl_a != ERR_ADDR) smem[sl_a] = sl_d;
        aw_got <= 0; w_got <= 0;
      end else begin
        aw_got <= sl_aw; s_awaddr <= sl_a;
        w_got <= sl_w; s_wdata <= sl_d;
      end
      if (s_bvalid && bus.bready) s_bvalid <= 0;
      if (bus.arvalid && bus.arready) begin
        ar_cnt <= 0;
        s_rvalid <= 1;
        s_rresp <= (bus.araddr == ERR_ADDR) ? 2'b10 : 2'b00;
        if (bus.araddr != ERR_ADDR && smem.exists(bus.araddr))
          s_rdata <= smem[bus.araddr];
        else s_rdata <= '0;
      end else begin
        if (bus.arvalid) ar_cnt <= ar_cnt + 1;
        if (s_rvalid && bus.rready) s_rvalid <= 0;
      end
    end
  end

  // ---------------- cycle counter and bus activity monitor
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int awv_cyc = 0, wv_cyc = 0, b_hs = 0, ar_hs = 0;
  always @(negedge clk) if (rst_n) begin
    awv_cyc += int'(bus.awvalid);
    wv_cyc  += int'(bus.wvalid);
    b_hs    += int'(bus.bvalid && bus.bready);
    ar_hs   += int'(bus.arvalid && bus.arready);
  end

  // ---------------- response model and per-cycle compare
  typedef struct {
    logic        we;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        expq[$];
  exp_t        cur;
  logic [31:0] mmem [logic [31:0]];
  int          model_err = 0;
  logic        rsp_open = 0;
  logic [31:0] last_rdata = '0;
  logic [1:0]  last_resp = '0;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_open = 0;
      model_err = 0;
    end else begin
      chk("busy_not_ready", o_busy, !o_cmd_ready);
      if (o_rsp_valid) begin
        if (!rsp_open) begin
          if (expq.size() == 0) begin
            checks++;
            $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response");
          end else begin
            cur = expq.pop_front();
            rsp_open = 1;
            if (cur.resp != 2'b00 && model_err < 65535) model_err++;
            chk("rsp_latency", 64'(cyc - cur.acc), 64'(cur.lat));
          end
        end
        if (rsp_open) begin
          chk("rsp_we", o_rsp_we, cur.we);
          chk("rsp_rdata", o_rsp_rdata, cur.rdata);
          chk("rsp_resp", o_rsp_resp, cur.resp);
          chk("cmd_ready_in_rsp", o_cmd_ready, 1'b0);
          last_rdata = o_rsp_rdata;
          last_resp = o_rsp_resp;
        end
        if (i_rsp_ready) rsp_open = 0;
      end
      chk("err_cnt", o_err_cnt, 16'(model_err));
    end
  end

  // ---------------- driver
  task automatic run_cmd(input logic we, input logic [31:0] addr,
                         input logic [31:0] wd, input int hold);
    exp_t e;
    int   n;
    int   ar0;
    e.we = we;
    e.resp = (addr == ERR_ADDR) ? 2'b10 : 2'b00;
    e.rdata = '0;
    e.lat = 3 + (we ? aw_delay : ar_delay);
`ifdef AXI4_LITE_CMD_MASTER_ALIGN_CHECK_EN
    if (addr[1:0] != 2'b00) begin
      e.resp = 2'b10;
      e.lat = 1;
    end
`endif
    if (!we && e.resp == 2'b00 && mmem.exists(addr)) e.rdata = mmem[addr];
    if (we && e.resp == 2'b00) mmem[addr] = wd;
    i_rsp_ready = (hold == 0);
    i_cmd_valid = 1; i_cmd_we = we; i_cmd_addr = addr;
    i_cmd_wdata = wd; i_cmd_wstrb = 4'hF;
    n = 0;
    do begin @(negedge clk); n++; end while (!o_cmd_ready && n < 50);
    if (!o_cmd_ready) begin
      checks++;
      $display("FAIL accept_timeout: got cmd_ready=0 expected 1");
      i_cmd_valid = 0;
      return;
    end
    @(posedge clk); #1;
    i_cmd_valid = 0;
    e.acc = cyc - 1;
    expq.push_back(e);
    n = 0;
    while (!o_rsp_valid && n < 50) begin @(negedge clk); n++; end
    if (!o_rsp_valid) begin
      checks++;
      $display("FAIL rsp_timeout: got rsp_valid=0 expected 1");
      return;
    end
    if (hold > 0) begin
      ar0 = ar_hs;
      repeat (hold) @(posedge clk);
      #1;
      chk("no_ar_while_held", 64'(ar_hs - ar0), 64'd0);
      i_rsp_ready = 1;
    end
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_cmd_ready"}, o_cmd_ready, 1'b1);
    chk({tag, "_busy"}, o_busy, 1'b0);
    chk({tag, "_rsp_valid"}, o_rsp_valid, 1'b0);
    chk({tag, "_rsp_we"}, o_rsp_we, 1'b0);
    chk({tag, "_rsp_rdata"}, o_rsp_rdata, 32'h0);
    chk({tag, "_rsp_resp"}, o_rsp_resp, 2'b00);
    chk({tag, "_err_cnt"}, o_err_cnt, 16'h0);
    chk({tag, "_valids"},
        {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}, 5'b0);
    chk({tag, "_awaddr"}, bus.awaddr, 32'h0);
    chk({tag, "_araddr"}, bus.araddr, 32'h0);
    chk({tag, "_wdata"}, bus.wdata, 32'h0);
    chk({tag, "_wstrb"}, bus.wstrb, 4'h0);
  endtask

  logic [31:0] wr_addr [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
  logic [31:0] wr_data [4] = '{32'h12345678, 32'h87654321,
                               32'hABCDEF01, 32'h10FEDCBA};

  int awv0, wv0, b0;

  initial begin
    repeat (20) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst_n = 1;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) run_cmd(1'b1, wr_addr[i], wr_data[i], 0);
    chk("wr_err_cnt_lit", o_err_cnt, 16'd0);
    chk("wr_resp_lit", last_resp, 2'b00);

    for (int i = 0; i < 4; i++) begin
      run_cmd(1'b0, wr_addr[i], 32'h0, 0);
      if (i == 0) chk("rd0_lit", last_rdata, 32'h12345678);
    end
    chk("rdC_lit", last_rdata, 32'h10FEDCBA);

    aw_delay = 3;
    awv0 = awv_cyc; wv0 = wv_cyc; b0 = b_hs;
    run_cmd(1'b1, 32'h10, 32'h55AA55AA, 0);
    chk("awvalid_cycles", 64'(awv_cyc - awv0), 64'd4);
    chk("wvalid_cycles", 64'(wv_cyc - wv0), 64'd1);
    chk("b_handshakes", 64'(b_hs - b0), 64'd1);
    aw_delay = 0;
    run_cmd(1'b0, 32'h10, 32'h0, 0);
    chk("rd10_lit", last_rdata, 32'h55AA55AA);

    run_cmd(1'b0, 32'h4, 32'h0, 5);
    chk("held_rd4_lit", last_rdata, 32'h87654321);

    run_cmd(1'b1, ERR_ADDR, 32'hDEADBEEF, 0);
    chk("err1_resp_lit", last_resp, 2'b10);
    run_cmd(1'b0, ERR_ADDR, 32'h0, 0);
    chk("err2_resp_lit", last_resp, 2'b10);
    run_cmd(1'b1, ERR_ADDR, 32'h0BADF00D, 0);
    chk("err3_resp_lit", last_resp, 2'b10);
    chk("err_cnt3_lit", o_err_cnt, 16'd3);

`ifdef AXI4_LITE_CMD_MASTER_ALIGN_CHECK_EN
    awv0 = awv_cyc;
    run_cmd(1'b1, 32'h2, 32'hCAFEF00D, 0);
    chk("misalign_no_aw", 64'(awv_cyc - awv0), 64'd0);
    chk("misalign_resp_lit", last_resp, 2'b10);
    chk("misalign_err_lit", o_err_cnt, 16'd4);
`endif

    ar_delay = 5;
    i_cmd_valid = 1; i_cmd_we = 0; i_cmd_addr = 32'h8;
    @(posedge clk); #1;
    i_cmd_valid = 0;
    begin
      int n;
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.arvalid && n < 20);
      chk("arvalid_before_reset", bus.arvalid, 1'b1);
    end
    rst_n = 0;
    #1;
    chk_reset_vals("midreset");
    ar_delay = 0;
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
